// File: rtl/cpu_sequencer_if.sv
// Instruction-fetch bus between the sequencer (master) and instruction memory (slave).
// imem_addr is held stable while imem_req is high until imem_ack completes the fetch.
interface cpu_sequencer_if #(
  parameter int unsigned PC_W = 8
) ();

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_rdata;
  logic            imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );

endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer for the 16-bit CPU.
// Fetches an instruction word, decodes opp/R1/R2/QR, drives the ALU opcode, register-file
// addresses and writeback, resolves jumps/HLT/RST and owns the program counter.
// Optional build macro SEQ_SINGLE_STEP_EN adds a 'step' input that executes one instruction
// from IDLE while run=0.
//
// Opcode map: 0 NOP, 1..10 ALU ops (ADD..SHFT), 11 MOV, 12 JMP, 13 JGO, 14 JLO, 15 JEO,
//             16 HLT, 17 RST, 18 SETH, 19 SETL, 20..31 illegal.
module cpu_sequencer #(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic            step,
`endif
  cpu_sequencer_if.master imem,
  output logic [4:0]      alu_op,
  output logic [2:0]      rf_addr_a,
  output logic [2:0]      rf_addr_b,
  output logic [2:0]      rf_waddr,
  output logic            rf_we,
  output logic [1:0]      wb_sel,
  output logic [7:0]      imm,
  input  logic            flag_gt,
  input  logic            flag_lt,
  input  logic            flag_eq,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            illegal
);

  localparam logic [PC_W-1:0] ResetPc = RESET_PC[PC_W-1:0];

  localparam logic [4:0] OpAdd  = 5'd1;
  localparam logic [4:0] OpMov  = 5'd11;
  localparam logic [4:0] OpJmp  = 5'd12;
  localparam logic [4:0] OpJgo  = 5'd13;
  localparam logic [4:0] OpJlo  = 5'd14;
  localparam logic [4:0] OpJeo  = 5'd15;
  localparam logic [4:0] OpHlt  = 5'd16;
  localparam logic [4:0] OpRst  = 5'd17;
  localparam logic [4:0] OpSeth = 5'd18;
  localparam logic [4:0] OpSetl = 5'd19;
  localparam logic [4:0] OpIllegalFirst = 5'd20;

  localparam logic [1:0] WbAlu  = 2'd0;
  localparam logic [1:0] WbMov  = 2'd1;
  localparam logic [1:0] WbSeth = 2'd2;
  localparam logic [1:0] WbSetl = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StWb,
    StHalt
  } state_e;

  state_e      state_q;
  logic [15:0] ir_q;
  logic        imem_req_q;

  // Instruction fields
  logic [4:0] opp;
  logic [2:0] r1;
  logic [2:0] r2;
  logic [2:0] qr;
  logic [7:0] off8;

  assign opp  = ir_q[15:11];
  assign r1   = ir_q[10:8];
  assign r2   = ir_q[7:5];
  assign qr   = ir_q[4:2];
  assign off8 = ir_q[7:0];

  assign imem.imem_req  = imem_req_q;
  assign imem.imem_addr = pc;

  // Leaving IDLE: run always; step too when single-step support is built in.
  logic start;
`ifdef SEQ_SINGLE_STEP_EN
  assign start = run | step;
`else
  assign start = run;
`endif

  // Next-PC candidates; the jump offset is sign-extended and wraps modulo 2^PC_W.
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_target;

  assign pc_inc    = pc + PC_W'(1);
  assign pc_target = pc + PC_W'($signed(off8));

  logic is_wb;
  logic is_illegal;

  assign is_wb      = ((opp >= OpAdd) && (opp <= OpMov)) || (opp == OpSeth) || (opp == OpSetl);
  assign is_illegal = (opp >= OpIllegalFirst);

  // Jump resolution against the compare flags seen during EXEC.
  logic jump_taken;
  always_comb begin
    jump_taken = 1'b0;
    case (opp)
      OpJmp:   jump_taken = 1'b1;
      OpJgo:   jump_taken = flag_gt;
      OpJlo:   jump_taken = flag_lt;
      OpJeo:   jump_taken = flag_eq;
      default: jump_taken = 1'b0;
    endcase
  end

  // Writeback destination and result-mux select for the current instruction.
  logic [1:0] wb_sel_nx;
  logic [2:0] waddr_nx;
  always_comb begin
    wb_sel_nx = WbAlu;
    waddr_nx  = qr;
    case (opp)
      OpMov: wb_sel_nx = WbMov;
      OpSeth: begin
        wb_sel_nx = WbSeth;
        waddr_nx  = r1;
      end
      OpSetl: begin
        wb_sel_nx = WbSetl;
        waddr_nx  = r1;
      end
      default: begin
        wb_sel_nx = WbAlu;
        waddr_nx  = qr;
      end
    endcase
  end

  // Sequencer FSM with registered outputs; rf_we and illegal are single-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pc         <= ResetPc;
      ir_q       <= '0;
      imem_req_q <= 1'b0;
      alu_op     <= '0;
      rf_addr_a  <= '0;
      rf_addr_b  <= '0;
      rf_waddr   <= '0;
      rf_we      <= 1'b0;
      wb_sel     <= '0;
      imm        <= '0;
      halted     <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      rf_we   <= 1'b0;
      illegal <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StFetch;
            imem_req_q <= 1'b1;
          end
        end

        // Address comes straight from pc, which does not move until the instruction retires.
        StFetch: begin
          if (imem.imem_ack) begin
            ir_q       <= imem.imem_rdata;
            imem_req_q <= 1'b0;
            state_q    <= StDecode;
          end
        end

        StDecode: begin
          alu_op    <= opp;
          rf_addr_a <= r1;
          rf_addr_b <= r2;
          imm       <= off8;
          illegal   <= is_illegal;
          state_q   <= StExec;
        end

        StExec: begin
          if (is_wb) begin
            rf_we    <= 1'b1;
            rf_waddr <= waddr_nx;
            wb_sel   <= wb_sel_nx;
            state_q  <= StWb;
          end else if (opp == OpHlt) begin
            halted  <= 1'b1;
            state_q <= StHalt;
          end else begin
            // NOP, jumps, RST and illegal opcodes retire here.
            if (opp == OpRst) begin
              pc <= ResetPc;
            end else if (jump_taken) begin
              pc <= pc_target;
            end else begin
              pc <= pc_inc;
            end
            state_q    <= run ? StFetch : StIdle;
            imem_req_q <= run;
          end
        end

        StWb: begin
          pc         <= pc_inc;
          state_q    <= run ? StFetch : StIdle;
          imem_req_q <= run;
        end

        // Only rst_n leaves HALT.
        StHalt: begin
          state_q <= StHalt;
        end

        default: begin
          state_q    <= StIdle;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: table-driven single-instruction vectors with a
// writeback scoreboard, plus hand-written HALT and reset-during-fetch sequences.
module tb_cpu_sequencer;

  localparam int unsigned PC_W = 8;

  localparam logic [4:0] OpNop  = 5'd0;
  localparam logic [4:0] OpAdd  = 5'd1;
  localparam logic [4:0] OpShft = 5'd10;
  localparam logic [4:0] OpMov  = 5'd11;
  localparam logic [4:0] OpJmp  = 5'd12;
  localparam logic [4:0] OpJgo  = 5'd13;
  localparam logic [4:0] OpJlo  = 5'd14;
  localparam logic [4:0] OpJeo  = 5'd15;
  localparam logic [4:0] OpHlt  = 5'd16;
  localparam logic [4:0] OpRst  = 5'd17;
  localparam logic [4:0] OpSeth = 5'd18;
  localparam logic [4:0] OpSetl = 5'd19;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            run = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
  logic            step = 1'b0;
`endif
  logic [4:0]      alu_op;
  logic [2:0]      rf_addr_a;
  logic [2:0]      rf_addr_b;
  logic [2:0]      rf_waddr;
  logic            rf_we;
  logic [1:0]      wb_sel;
  logic [7:0]      imm;
  logic            flag_gt = 1'b0;
  logic            flag_lt = 1'b0;
  logic            flag_eq = 1'b0;
  logic [PC_W-1:0] pc;
  logic            halted;
  logic            illegal;

  cpu_sequencer_if #(.PC_W(PC_W)) imem_bus ();

  cpu_sequencer #(
    .PC_W     (PC_W),
    .RESET_PC (0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
`ifdef SEQ_SINGLE_STEP_EN
    .step      (step),
`endif
    .imem      (imem_bus),
    .alu_op    (alu_op),
    .rf_addr_a (rf_addr_a),
    .rf_addr_b (rf_addr_b),
    .rf_waddr  (rf_waddr),
    .rf_we     (rf_we),
    .wb_sel    (wb_sel),
    .imm       (imm),
    .flag_gt   (flag_gt),
    .flag_lt   (flag_lt),
    .flag_eq   (flag_eq),
    .pc        (pc),
    .halted    (halted),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  // Instruction memory with a programmable number of wait cycles before ack.
  logic [15:0] mem [256];
  int          ack_delay = 0;
  int          wait_cnt = 0;

  assign imem_bus.imem_rdata = mem[imem_bus.imem_addr];
  assign imem_bus.imem_ack   = imem_bus.imem_req && (wait_cnt >= ack_delay);

  always @(posedge clk) begin
    if (!imem_bus.imem_req || imem_bus.imem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  typedef struct {
    logic [2:0] waddr;
    logic [1:0] wsel;
    logic [4:0] op;
    logic [7:0] imm;
    logic       chk_imm;
  } wb_t;

  typedef struct {
    logic [15:0] instr;
    logic [2:0]  flags;   // {gt, lt, eq}
    int          delay;
    logic [7:0]  pc_exp;
    logic        we;
    logic [2:0]  waddr;
    logic [1:0]  wsel;
    logic        ill;
    int          we_ofs;  // rf_we cycle minus first imem_req cycle
  } vec_t;

  wb_t  exp_q [$];
  wb_t  mon_e;
  vec_t vecs [22];

  int n_cmp = 0;
  int n_fail = 0;

  int         cyc = 0;
  int         first_req = -1;
  int         we_cyc = -1;
  int         we_cnt = 0;
  int         ill_cnt = 0;
  int         req_cnt = 0;
  int         addr_glitch = 0;
  logic       req_prev = 1'b0;
  logic       ack_prev = 1'b0;
  logic [7:0] addr_prev = '0;
  logic [7:0] last_fetch_addr = '0;
  logic [7:0] cur_pc = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] enc_r(input logic [4:0] op, input logic [2:0] r1,
                                        input logic [2:0] r2, input logic [2:0] qr);
    return {op, r1, r2, qr, 2'b00};
  endfunction

  function automatic logic [15:0] enc_i(input logic [4:0] op, input logic [2:0] r1,
                                        input logic [7:0] off);
    return {op, r1, off};
  endfunction

  function automatic vec_t mk(input logic [15:0] instr, input logic [2:0] flags, input int delay,
                              input logic [7:0] pc_exp, input logic we, input logic [2:0] waddr,
                              input logic [1:0] wsel, input logic ill, input int we_ofs);
    vec_t v;
    v.instr = instr;   v.flags = flags; v.delay = delay; v.pc_exp = pc_exp;
    v.we = we;         v.waddr = waddr; v.wsel = wsel;   v.ill = ill;
    v.we_ofs = we_ofs;
    return v;
  endfunction

  // Monitor: fetch tracking, address stability, writeback scoreboard, illegal pulses.
  always @(negedge clk) begin
    cyc++;
    if (imem_bus.imem_req) begin
      req_cnt++;
      if (!req_prev || ack_prev) begin
        last_fetch_addr = imem_bus.imem_addr;
        if (first_req < 0) first_req = cyc;
      end else if (imem_bus.imem_addr !== addr_prev) begin
        addr_glitch++;
      end
    end
    if (rf_we) begin
      we_cnt++;
      we_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_unexpected_we: got rf_we=1 waddr=%0d, required no write", rf_waddr);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_waddr", 32'(rf_waddr), 32'(mon_e.waddr));
        check("sb_wb_sel", 32'(wb_sel), 32'(mon_e.wsel));
        check("sb_alu_op", 32'(alu_op), 32'(mon_e.op));
        if (mon_e.chk_imm) check("sb_imm", 32'(imm), 32'(mon_e.imm));
      end
    end
    if (illegal) ill_cnt++;
    req_prev  = imem_bus.imem_req;
    ack_prev  = imem_bus.imem_ack;
    addr_prev = imem_bus.imem_addr;
  end

  task automatic clear_counters();
    first_req = -1; we_cyc = -1; we_cnt = 0; ill_cnt = 0; req_cnt = 0; addr_glitch = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cur_pc = '0;
    exp_q.delete();
  endtask

  // One instruction: pulse run for a single cycle, let it retire, then check its effects.
  task automatic run_vec(input int idx, input vec_t v);
    wb_t e;
    mem[cur_pc] = v.instr;
    {flag_gt, flag_lt, flag_eq} = v.flags;
    ack_delay = v.delay;
    if (v.we) begin
      e.waddr   = v.waddr;
      e.wsel    = v.wsel;
      e.op      = v.instr[15:11];
      e.imm     = v.instr[7:0];
      e.chk_imm = (v.wsel >= 2'd2);
      exp_q.push_back(e);
    end
    clear_counters();
    run = 1'b1;
    @(posedge clk);
    #1 run = 1'b0;
    repeat (v.delay + 6) @(posedge clk);
    #1;
    check($sformatf("v%0d_pc", idx), 32'(pc), 32'(v.pc_exp));
    check($sformatf("v%0d_fetch_addr", idx), 32'(last_fetch_addr), 32'(cur_pc));
    check($sformatf("v%0d_req_cycles", idx), 32'(req_cnt), 32'(v.delay + 1));
    check($sformatf("v%0d_addr_stable", idx), 32'(addr_glitch), 32'd0);
    check($sformatf("v%0d_we_count", idx), 32'(we_cnt), 32'(v.we));
    check($sformatf("v%0d_illegal_count", idx), 32'(ill_cnt), 32'(v.ill));
    if (v.we) check($sformatf("v%0d_we_latency", idx), 32'(we_cyc - first_req), 32'(v.we_ofs));
    cur_pc = v.pc_exp;
  endtask

  initial begin
    vec_t pre;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

    //            instr                            flags   dly pc_exp  we waddr wsel ill ofs
    vecs[0]  = mk(enc_r(OpAdd, 3'd1, 3'd2, 3'd3),  3'b000, 0, 8'd1,   1, 3'd3, 2'd0, 0, 3);
    vecs[1]  = mk(enc_i(OpSeth, 3'd5, 8'hA5),      3'b000, 3, 8'd2,   1, 3'd5, 2'd2, 0, 6);
    vecs[2]  = mk(enc_r(OpMov, 3'd0, 3'd4, 3'd7),  3'b000, 1, 8'd3,   1, 3'd7, 2'd1, 0, 4);
    vecs[3]  = mk(enc_i(OpSetl, 3'd2, 8'h3C),      3'b000, 0, 8'd4,   1, 3'd2, 2'd3, 0, 3);
    vecs[4]  = mk(enc_r(OpShft, 3'd3, 3'd1, 3'd6), 3'b000, 2, 8'd5,   1, 3'd6, 2'd0, 0, 5);
    vecs[5]  = mk(enc_i(OpJmp, 3'd0, 8'h05),       3'b000, 0, 8'd10,  0, 3'd0, 2'd0, 0, 0);
    vecs[6]  = mk(enc_i(OpJeo, 3'd0, 8'hFC),       3'b001, 0, 8'd6,   0, 3'd0, 2'd0, 0, 0);
    vecs[7]  = mk(enc_i(OpJmp, 3'd0, 8'h04),       3'b000, 0, 8'd10,  0, 3'd0, 2'd0, 0, 0);
    vecs[8]  = mk(enc_i(OpJeo, 3'd0, 8'hFC),       3'b110, 0, 8'd11,  0, 3'd0, 2'd0, 0, 0);
    vecs[9]  = mk(enc_i(OpJgo, 3'd0, 8'h03),       3'b100, 0, 8'd14,  0, 3'd0, 2'd0, 0, 0);
    vecs[10] = mk(enc_i(OpJgo, 3'd0, 8'h03),       3'b011, 0, 8'd15,  0, 3'd0, 2'd0, 0, 0);
    vecs[11] = mk(enc_i(OpJlo, 3'd0, 8'hFB),       3'b010, 0, 8'd10,  0, 3'd0, 2'd0, 0, 0);
    vecs[12] = mk(enc_i(OpJlo, 3'd0, 8'hFB),       3'b101, 0, 8'd11,  0, 3'd0, 2'd0, 0, 0);
    vecs[13] = mk(enc_i(OpNop, 3'd0, 8'h00),       3'b000, 2, 8'd12,  0, 3'd0, 2'd0, 0, 0);
    vecs[14] = mk(enc_r(5'd25, 3'd7, 3'd7, 3'd7),  3'b000, 0, 8'd13,  0, 3'd0, 2'd0, 1, 0);
    vecs[15] = mk(enc_i(5'd31, 3'd1, 8'h55),       3'b111, 0, 8'd14,  0, 3'd0, 2'd0, 1, 0);
    vecs[16] = mk(enc_i(OpRst, 3'd0, 8'h00),       3'b000, 1, 8'd0,   0, 3'd0, 2'd0, 0, 0);
    vecs[17] = mk(enc_i(OpJmp, 3'd0, 8'hFF),       3'b000, 0, 8'd255, 0, 3'd0, 2'd0, 0, 0);
    vecs[18] = mk(enc_i(OpNop, 3'd0, 8'h00),       3'b000, 0, 8'd0,   0, 3'd0, 2'd0, 0, 0);
    vecs[19] = mk(enc_i(OpJmp, 3'd0, 8'h7F),       3'b000, 0, 8'd127, 0, 3'd0, 2'd0, 0, 0);
    vecs[20] = mk(enc_i(OpJmp, 3'd0, 8'h80),       3'b000, 0, 8'd255, 0, 3'd0, 2'd0, 0, 0);
    vecs[21] = mk(enc_r(OpAdd, 3'd4, 3'd5, 3'd1),  3'b000, 0, 8'd0,   1, 3'd1, 2'd0, 0, 3);

    // Reset state, then 20 idle cycles with run=0.
    rst_n = 1'b0;
    #2;
    check("reset_imem_addr", 32'(imem_bus.imem_addr), 32'd0);
    check("reset_outputs", {imem_bus.imem_req, rf_we, halted, illegal, alu_op, wb_sel, rf_waddr},
          32'd0);
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_outputs", {imem_bus.imem_req, pc, rf_we, halted}, 32'd0);
    end

    for (int i = 0; i < 22; i++) run_vec(i, vecs[i]);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    // Illegal opcode followed by HLT, run held high.
    do_reset();
    mem[0] = enc_r(5'd25, 3'd1, 3'd2, 3'd3);
    mem[1] = enc_i(OpHlt, 3'd0, 8'h00);
    ack_delay = 0;
    clear_counters();
    run = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("hlt_halted", 32'(halted), 32'd1);
    check("hlt_illegal_pulses", 32'(ill_cnt), 32'd1);
    check("hlt_fetch_addr", 32'(last_fetch_addr), 32'd1);
    check("hlt_we_count", 32'(we_cnt), 32'd0);
    req_cnt = 0;
    repeat (20) @(posedge clk);
    #1;
    check("hlt_no_fetch", 32'(req_cnt), 32'd0);
    check("hlt_still_halted", 32'(halted), 32'd1);
    run = 1'b0;

    // Reset asserted in the middle of a stalled fetch.
    do_reset();
    pre = mk(enc_i(OpJmp, 3'd0, 8'h05), 3'b000, 0, 8'd5, 0, 3'd0, 2'd0, 0, 0);
    run_vec(100, pre);
    mem[5] = enc_r(OpAdd, 3'd1, 3'd1, 3'd2);
    ack_delay = 5;
    clear_counters();
    run = 1'b1;
    @(posedge clk);
    #1 run = 1'b0;
    @(posedge clk);
    #3;
    check("rstf_fetch_pending", {24'd0, imem_bus.imem_req, pc[6:0]}, {24'd0, 1'b1, 7'd5});
    rst_n = 1'b0;
    #1;
    check("rstf_req_drop", 32'(imem_bus.imem_req), 32'd0);
    check("rstf_pc", 32'(pc), 32'd0);
    check("rstf_addr", 32'(imem_bus.imem_addr), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("rstf_no_we", 32'(we_cnt), 32'd0);
    check("rstf_idle", {imem_bus.imem_req, pc, halted}, 32'd0);
    check("rstf_sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
